// File: rtl/exc_ctrl.sv
// Exception/interrupt commit controller for cp0.
// Picks the highest-priority event from the MEM-stage commit slot, waits for
// outstanding data-bus traffic, then presents one COMMIT cycle to cp0 with
// flush and fetch redirect, followed by optional extra flush cycles.
//
// state  | meaning
// IDLE   | watching the commit slot for an interrupt, exception or ERET
// WAIT   | event latched, pipeline stalled until the data bus goes idle
// COMMIT | one cycle: cp0 exception inputs valid, redirect strobe, flush
// FLUSH  | flush held for the remaining FLUSH_CYCLES-1 cycles
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [7:0]  WAIT_LIMIT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic        commit_in_delayslot_i,
    input  logic [6:0]  commit_exc_i,
    input  logic        commit_eret_i,
    input  logic [31:0] commit_dvaddr_i,
    input  logic        mem_busy_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [4:0]  excepttype_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] badvaddr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        timeout_err_o
);
    // cp0 cause codes; zero means no exception
    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_FLUSH} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;
    logic [7:0]  flush_cnt;
    logic        stall_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic [31:0] badv_q;

    logic        int_pend;
    logic        detect;
    logic        go_commit;
    logic [4:0]  det_code;
    logic [31:0] det_badv;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc;
    logic        sel_ds;
    logic [31:0] sel_badv;
    logic        unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign int_pend = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));
    assign detect   = (state == S_IDLE) & commit_valid_i
                      & (int_pend | (|commit_exc_i) | commit_eret_i);
    assign wait_nxt = wait_cnt + 8'd1;

    // priority encode the event and choose the bad virtual address
    always_comb begin
        det_code = 5'h00;
        det_badv = 32'h0;
        if (int_pend)                det_code = EXC_INT;
        else if (commit_exc_i[6]) begin
            det_code = EXC_ADEL;
            det_badv = commit_pc_i;
        end
        else if (commit_exc_i[5])    det_code = EXC_RI;
        else if (commit_exc_i[4])    det_code = EXC_OV;
        else if (commit_exc_i[3])    det_code = EXC_SYS;
        else if (commit_exc_i[2])    det_code = EXC_BP;
        else if (commit_exc_i[1]) begin
            det_code = EXC_ADEL;
            det_badv = commit_dvaddr_i;
        end
        else if (commit_exc_i[0]) begin
            det_code = EXC_ADES;
            det_badv = commit_dvaddr_i;
        end
        else if (commit_eret_i)      det_code = EXC_ERET;
    end

    // commit straight from IDLE uses the live detection, from WAIT the latches
    always_comb begin
        go_commit = (detect & ~mem_busy_i)
                    | ((state == S_WAIT) & (~mem_busy_i | (wait_nxt == WAIT_LIMIT)));
        sel_code  = (state == S_IDLE) ? det_code              : code_q;
        sel_pc    = (state == S_IDLE) ? commit_pc_i           : pc_q;
        sel_ds    = (state == S_IDLE) ? commit_in_delayslot_i : ds_q;
        sel_badv  = (state == S_IDLE) ? det_badv              : badv_q;
    end

    assign stall_o       = stall_q | detect;
    assign redirect_pc_o = !redirect_valid_o ? 32'h0
                         : (excepttype_o == EXC_ERET) ? epc_i : EXC_VECTOR;

    // sequencing FSM with registered cp0/flush/redirect outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            wait_cnt            <= 8'd0;
            flush_cnt           <= 8'd0;
            stall_q             <= 1'b0;
            code_q              <= 5'h00;
            pc_q                <= 32'h0;
            ds_q                <= 1'b0;
            badv_q              <= 32'h0;
            excepttype_o        <= 5'h00;
            is_in_delayslot_o   <= 1'b0;
            current_inst_addr_o <= 32'h0;
            badvaddr_o          <= 32'h0;
            flush_o             <= 1'b0;
            redirect_valid_o    <= 1'b0;
            timeout_err_o       <= 1'b0;
        end else begin
            excepttype_o        <= 5'h00;
            is_in_delayslot_o   <= 1'b0;
            current_inst_addr_o <= 32'h0;
            badvaddr_o          <= 32'h0;
            redirect_valid_o    <= 1'b0;

            if (go_commit) begin
                state               <= S_COMMIT;
                stall_q             <= 1'b1;
                flush_o             <= 1'b1;
                redirect_valid_o    <= 1'b1;
                excepttype_o        <= sel_code;
                is_in_delayslot_o   <= sel_ds;
                current_inst_addr_o <= sel_pc;
                badvaddr_o          <= sel_badv;
            end

            case (state)
                S_IDLE: begin
                    if (detect) begin
                        code_q <= det_code;
                        pc_q   <= commit_pc_i;
                        ds_q   <= commit_in_delayslot_i;
                        badv_q <= det_badv;
                        if (mem_busy_i) begin
                            state    <= S_WAIT;
                            stall_q  <= 1'b1;
                            wait_cnt <= 8'd0;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (go_commit && mem_busy_i) timeout_err_o <= 1'b1;
                end
                S_COMMIT: begin
                    stall_q <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state     <= S_FLUSH;
                        flush_cnt <= 8'd1;
                    end else begin
                        state   <= S_IDLE;
                        flush_o <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt >= FLUSH_LAST) begin
                        state   <= S_IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
